// File: rtl/bp_axi_mem_bridge.sv
// Bridges BlackParrot memory commands onto AXI4 INCR bursts, one transaction outstanding at a time.
// Commands below the DRAM base are answered locally with an error response and never reach AXI.
module bp_axi_mem_bridge #(
  parameter int paddr_width_p = 34,
  parameter int data_width_p = 64,
  parameter int axi_addr_width_p = 32,
  parameter logic [paddr_width_p-1:0] dram_base_p = paddr_width_p'(34'h0_8000_0000),
  parameter int max_len_p = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic                        cmd_v_i,
  output logic                        cmd_ready_and_o,
  input  logic [paddr_width_p-1:0]    cmd_addr_i,
  input  logic                        cmd_wr_i,
  input  logic [1:0]                  cmd_len_i,
  input  logic [data_width_p-1:0]     cmd_data_i,
  input  logic                        cmd_data_v_i,
  output logic                        cmd_data_ready_and_o,

  output logic                        resp_v_o,
  input  logic                        resp_ready_and_i,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic                        resp_wr_o,
  output logic                        resp_last_o,
  output logic                        resp_err_o,

  output logic [axi_addr_width_p-1:0] m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [data_width_p-1:0]     m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,

  output logic [axi_addr_width_p-1:0] m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [data_width_p-1:0]     m_axi_wdata,
  output logic [data_width_p/8-1:0]   m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);

  localparam int cnt_w_lp = $clog2(max_len_p);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, ERR
  } state_e;

  state_e                      state_r;
  logic [axi_addr_width_p-1:0] addr_r;
  logic [1:0]                  len_r;
  logic                        wr_r;
  logic [cnt_w_lp-1:0]         beat_cnt_r;
  logic                        bresp_err_r;
  logic                        resp_pend_r;
  logic                        cmd_ready_r;
  logic                        arvalid_r;
  logic                        awvalid_r;
  logic                        bready_r;

  logic [paddr_width_p-1:0]    addr_off;
  logic                        last_beat;
  logic                        rd_data_st;
  logic                        wr_data_st;
  logic                        drain_st;
  logic                        wr_resp_pend;
  logic                        err_resp_pend;

  assign addr_off  = cmd_addr_i - dram_base_p;
  assign last_beat = (beat_cnt_r == cnt_w_lp'(len_r));

  // cmd_ready is a register so it stays low through reset and the first cycle after it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      len_r       <= '0;
      wr_r        <= 1'b0;
      beat_cnt_r  <= '0;
      bresp_err_r <= 1'b0;
      resp_pend_r <= 1'b0;
      cmd_ready_r <= 1'b0;
      arvalid_r   <= 1'b0;
      awvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_ready_r && cmd_v_i) begin
            cmd_ready_r <= 1'b0;
            addr_r      <= addr_off[axi_addr_width_p-1:0];
            len_r       <= cmd_len_i;
            wr_r        <= cmd_wr_i;
            beat_cnt_r  <= '0;
            bresp_err_r <= 1'b0;
            if (cmd_addr_i < dram_base_p) begin
              state_r     <= ERR;
              resp_pend_r <= ~cmd_wr_i;
            end else if (cmd_wr_i) begin
              state_r   <= WR_ADDR;
              awvalid_r <= 1'b1;
            end else begin
              state_r   <= RD_ADDR;
              arvalid_r <= 1'b1;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid && resp_ready_and_i && m_axi_rlast) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) begin
            awvalid_r <= 1'b0;
            state_r   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (cmd_data_v_i && m_axi_wready) begin
            beat_cnt_r <= beat_cnt_r + 1'b1;
            if (last_beat) begin
              state_r  <= WR_RESP;
              bready_r <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (bready_r && m_axi_bvalid) begin
            bready_r    <= 1'b0;
            bresp_err_r <= m_axi_bresp[1];
            resp_pend_r <= 1'b1;
          end else if (resp_pend_r && resp_ready_and_i) begin
            resp_pend_r <= 1'b0;
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
          end
        end
        ERR: begin
          // Rejected writes still swallow their data beats so the producer is not left stuck
          if (!resp_pend_r) begin
            if (cmd_data_v_i) begin
              beat_cnt_r <= beat_cnt_r + 1'b1;
              if (last_beat) resp_pend_r <= 1'b1;
            end
          end else if (resp_ready_and_i) begin
            resp_pend_r <= 1'b0;
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign rd_data_st    = (state_r == RD_DATA);
  assign wr_data_st    = (state_r == WR_DATA);
  assign drain_st      = (state_r == ERR) && !resp_pend_r;
  assign wr_resp_pend  = (state_r == WR_RESP) && resp_pend_r;
  assign err_resp_pend = (state_r == ERR) && resp_pend_r;

  assign cmd_ready_and_o      = cmd_ready_r;
  assign cmd_data_ready_and_o = (wr_data_st && m_axi_wready) || drain_st;

  // Read beats pass straight through so the read path adds no latency
  assign resp_v_o    = rd_data_st ? m_axi_rvalid : (wr_resp_pend || err_resp_pend);
  assign resp_data_o = rd_data_st ? m_axi_rdata : '0;
  assign resp_last_o = rd_data_st ? m_axi_rlast : (wr_resp_pend || err_resp_pend);
  assign resp_err_o  = rd_data_st ? m_axi_rresp[1]
                     : ((wr_resp_pend && bresp_err_r) || err_resp_pend);
  assign resp_wr_o   = wr_resp_pend || (err_resp_pend && wr_r);

  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = 8'(len_r);
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rd_data_st && resp_ready_and_i;

  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = 8'(len_r);
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wvalid  = wr_data_st && cmd_data_v_i;
  assign m_axi_wdata   = wr_data_st ? cmd_data_i : '0;
  assign m_axi_wstrb   = wr_data_st ? '1 : '0;
  assign m_axi_wlast   = wr_data_st && last_beat;
  assign m_axi_bready  = bready_r;

  logic unused_ok;
  assign unused_ok = &{1'b0, m_axi_rresp[0], m_axi_bresp[0],
                       addr_off[paddr_width_p-1:axi_addr_width_p]};

endmodule

// File: tb/tb_bp_axi_mem_bridge.sv
// Self-checking bench for bp_axi_mem_bridge: a table of transactions driven through a
// cycle-based AXI slave model, with expected response beats queued in a scoreboard.
`timescale 1ns/1ps
module tb_bp_axi_mem_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_v_i, cmd_ready_and_o, cmd_wr_i, cmd_data_v_i, cmd_data_ready_and_o;
  logic [33:0] cmd_addr_i;
  logic [1:0]  cmd_len_i;
  logic [63:0] cmd_data_i;
  logic        resp_v_o, resp_ready_and_i, resp_wr_o, resp_last_o, resp_err_o;
  logic [63:0] resp_data_o;
  logic [31:0] m_axi_araddr, m_axi_awaddr;
  logic [7:0]  m_axi_arlen, m_axi_awlen, m_axi_wstrb;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_rdata, m_axi_wdata;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;

  always #5 aclk = ~aclk;

  bp_axi_mem_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_addr_i(cmd_addr_i),
    .cmd_wr_i(cmd_wr_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .cmd_data_v_i(cmd_data_v_i), .cmd_data_ready_and_o(cmd_data_ready_and_o),
    .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i), .resp_data_o(resp_data_o),
    .resp_wr_o(resp_wr_o), .resp_last_o(resp_last_o), .resp_err_o(resp_err_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    logic            wr;
    logic [33:0]     addr;
    logic [1:0]      len;
    logic [3:0][63:0] data;
    logic [31:0]     exp_ax;
    logic            exp_err_path;
    int              ax_delay;
    logic            wtoggle;
    int              err_beat;
    logic [1:0]      bresp;
    int              low_at;
    int              low_len;
    int              rst_after_w;
  } txn_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
    logic        wr;
  } resp_t;

  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [33:0] addr, input logic [1:0] len,
                              input logic [31:0] exp_ax, input logic exp_err, input int ax_delay,
                              input logic wtog, input int err_beat, input logic [1:0] bresp,
                              input int low_at, input int low_len, input int seed);
    txn_t t;
    t.wr = wr; t.addr = addr; t.len = len; t.exp_ax = exp_ax; t.exp_err_path = exp_err;
    t.ax_delay = ax_delay; t.wtoggle = wtog; t.err_beat = err_beat; t.bresp = bresp;
    t.low_at = low_at; t.low_len = low_len; t.rst_after_w = 0;
    for (int b = 0; b < 4; b++)
      t.data[b] = {16'hC0DE, 8'(seed), 8'(b), 32'h1234_0000 + 32'(seed * 16 + b)};
    return t;
  endfunction

  task automatic driveIdle();
    cmd_v_i = 0; cmd_addr_i = '0; cmd_wr_i = 0; cmd_len_i = '0; cmd_data_i = '0; cmd_data_v_i = 0;
    resp_ready_and_i = 0; m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready_and_o, 0);
    checkOutput({tag, "_cmd_data_ready"}, cmd_data_ready_and_o, 0);
    checkOutput({tag, "_valids"}, {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, resp_v_o}, 0);
    checkOutput({tag, "_readies"}, {m_axi_rready, m_axi_bready}, 0);
    checkOutput({tag, "_last_err"}, {m_axi_wlast, resp_last_o, resp_err_o}, 0);
    checkOutput({tag, "_addr"}, {m_axi_araddr, m_axi_awaddr}, 0);
    checkOutput({tag, "_len"}, {m_axi_arlen, m_axi_awlen}, 0);
  endtask

  // One transaction, one negedge per cycle: drive the slave/producer, then sample at +1ns
  task automatic applyStimulus(input txn_t t);
    int   beats = int'(t.len) + 1;
    int   w_sent = 0, r_sent = 0, av_cnt = 0;
    bit   ar_done = 0, aw_done = 0, w_done = 0, b_done = 0, ax_pend = 0, finished = 0;
    logic [31:0] ax_prev = '0;
    logic rdy, acc, v, r, chan_done;
    logic [31:0] a;
    logic [7:0]  l;

    if (t.exp_err_path) sb.push_back('{64'h0, 1'b1, 1'b1, t.wr});
    else if (t.wr)      sb.push_back('{64'h0, 1'b1, t.bresp[1], 1'b1});
    else for (int b = 0; b < beats; b++)
      sb.push_back('{t.data[b], (b == beats - 1), (b == t.err_beat), 1'b0});

    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge aclk);
      rdy = !(cyc >= t.low_at && cyc < t.low_at + t.low_len);
      cmd_v_i = (cyc == 0); cmd_addr_i = t.addr; cmd_wr_i = t.wr; cmd_len_i = t.len;
      cmd_data_v_i = t.wr && cyc >= 1 && w_sent < beats;
      cmd_data_i = (w_sent < 4) ? t.data[2'(w_sent)] : '0;
      m_axi_arready = (av_cnt >= t.ax_delay);
      m_axi_awready = (av_cnt >= t.ax_delay);
      m_axi_wready = t.wtoggle ? (cyc % 2 == 1) : 1'b1;
      m_axi_rvalid = ar_done && r_sent < beats;
      m_axi_rdata = (r_sent < 4) ? t.data[2'(r_sent)] : '0;
      m_axi_rlast = (r_sent == beats - 1);
      m_axi_rresp = (r_sent == t.err_beat) ? 2'b10 : 2'b00;
      m_axi_bvalid = w_done && !b_done;
      m_axi_bresp = t.bresp;
      resp_ready_and_i = rdy;
      #1;

      if (cyc == 0) begin
        checkOutput("cmd_ready_idle", cmd_ready_and_o, 1);
        checkOutput("no_comb_valid", {m_axi_arvalid, m_axi_awvalid}, 0);
      end
      if (cyc == 1) begin
        checkOutput("arvalid_next", m_axi_arvalid, !t.wr && !t.exp_err_path);
        checkOutput("awvalid_next", m_axi_awvalid, t.wr && !t.exp_err_path);
      end
      if (t.exp_err_path)
        checkOutput("err_axi_quiet", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 0);

      // Response side, using counts from before this cycle's handshakes
      if (t.exp_err_path && t.wr)
        checkOutput("drain_before_resp", resp_v_o && (w_sent < beats), 0);
      if (resp_v_o && rdy) begin
        resp_t e;
        if (sb.size() == 0) checkOutput("resp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          checkOutput("resp_data", resp_data_o, e.data);
          checkOutput("resp_last", resp_last_o, e.last);
          checkOutput("resp_err", resp_err_o, e.err);
          checkOutput("resp_wr", resp_wr_o, e.wr);
          if (sb.size() == 0) finished = 1;
        end
      end

      if (!t.wr && !t.exp_err_path && ar_done && r_sent < beats)
        checkOutput("rready_track", m_axi_rready, rdy);
      if (m_axi_rvalid && m_axi_rready) r_sent++;

      acc = cmd_data_v_i && cmd_data_ready_and_o;
      if (t.wr && !t.exp_err_path) begin
        checkOutput("w_before_aw", m_axi_wvalid && !aw_done, 0);
        checkOutput("w_hs", m_axi_wvalid && m_axi_wready, acc);
        if (acc) begin
          checkOutput("wdata", m_axi_wdata, t.data[2'(w_sent)]);
          checkOutput("wlast", m_axi_wlast, w_sent == beats - 1);
          checkOutput("wstrb", m_axi_wstrb, 8'hFF);
          if (w_sent == beats - 1) w_done = 1;
          w_sent++;
        end
      end else if (acc) begin
        w_sent++;
      end

      if (!t.exp_err_path) begin
        v = t.wr ? m_axi_awvalid : m_axi_arvalid;
        r = t.wr ? m_axi_awready : m_axi_arready;
        a = t.wr ? m_axi_awaddr : m_axi_araddr;
        l = t.wr ? m_axi_awlen : m_axi_arlen;
        chan_done = t.wr ? aw_done : ar_done;
        if (ax_pend) checkOutput("ax_hold", {v, a}, {1'b1, ax_prev});
        if (v && !chan_done) begin
          if (r) begin
            checkOutput("axaddr", a, t.exp_ax);
            checkOutput("axlen", l, 8'(t.len));
            if (t.wr) aw_done = 1; else ar_done = 1;
            ax_pend = 0;
          end else begin
            ax_pend = 1; ax_prev = a; av_cnt++;
          end
        end
      end

      if (m_axi_bvalid && m_axi_bready) b_done = 1;

      if (t.rst_after_w > 0 && w_sent == t.rst_after_w) begin
        aresetn = 0;
        #1;
        checkResetState("mid_rst");
        sb.delete();
        driveIdle();
        @(negedge aclk);
        checkOutput("mid_rst_no_resp", resp_v_o, 0);
        aresetn = 1;
        finished = 1;
      end
    end
    if (!finished) checkOutput("txn_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    txn_t vec[10];
    txn_t t;

    vec[0] = mk(0, 34'h0_8000_1000, 2'd3, 32'h0000_1000, 0, 0, 0, -1, 2'b00, 0, 0, 1);
    vec[1] = mk(1, 34'h0_8000_0040, 2'd0, 32'h0000_0040, 0, 0, 0, -1, 2'b00, 0, 0, 2);
    vec[1].data[0] = 64'hDEAD_BEEF;
    vec[2] = mk(1, 34'h0_8000_2000, 2'd3, 32'h0000_2000, 0, 5, 1, -1, 2'b00, 0, 0, 3);
    vec[3] = mk(0, 34'h0_0000_1000, 2'd0, 32'h0, 1, 0, 0, -1, 2'b00, 0, 0, 4);
    vec[4] = mk(0, 34'h0_8000_3008, 2'd3, 32'h0000_3008, 0, 0, 0, 1, 2'b00, 2, 3, 5);
    vec[5] = mk(1, 34'h0_0000_0100, 2'd1, 32'h0, 1, 0, 0, -1, 2'b00, 0, 0, 6);
    vec[6] = mk(1, 34'h0_8000_0080, 2'd1, 32'h0000_0080, 0, 2, 0, -1, 2'b10, 0, 0, 7);
    vec[7] = mk(0, 34'h0_8000_0000, 2'd1, 32'h0000_0000, 0, 1, 0, -1, 2'b00, 0, 0, 8);
    vec[8] = mk(0, 34'h0_7FFF_FFF8, 2'd0, 32'h0, 1, 0, 0, -1, 2'b00, 0, 0, 9);
    vec[9] = mk(0, 34'h3_8000_0010, 2'd1, 32'h0000_0010, 0, 0, 0, -1, 2'b00, 0, 0, 10);

    driveIdle();
    #2;
    checkResetState("por");
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);

    for (int i = 0; i < 10; i++) applyStimulus(vec[i]);

    // Reset pulsed while write beat 2 is on the bus, then a clean read afterwards
    t = mk(1, 34'h0_8000_0400, 2'd3, 32'h0000_0400, 0, 0, 0, -1, 2'b00, 0, 0, 11);
    t.rst_after_w = 2;
    applyStimulus(t);
    t = mk(0, 34'h0_8000_0500, 2'd2, 32'h0000_0500, 0, 1, 0, -1, 2'b00, 0, 0, 12);
    applyStimulus(t);

    @(negedge aclk);
    driveIdle();
    @(negedge aclk);
    checkOutput("final_idle_ready", cmd_ready_and_o, 1);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_axi_mem_bridge.md
BP_AXI_MEM_BRIDGE -- requirements
Module: bp_axi_mem_bridge

Interface
REQ-001 SHALL have parameter paddr_width_p, default 34, meaning BP physical address width.
REQ-002 SHALL have parameter data_width_p, default 64, meaning BedRock fill width and AXI data width.
REQ-003 SHALL have parameter axi_addr_width_p, default 32, meaning AXI address width.
REQ-004 SHALL have parameter dram_base_p, default 34'h0_8000_0000, meaning BP DRAM base, subtracted before AXI issue.
REQ-005 SHALL have parameter max_len_p, default 4, meaning maximum beats per burst (256b block / 64b fill).
REQ-006 SHALL have ports:
- aclk  in  1  clock; aresetn  in  1  reset, asynchronous, active-low.
- cmd_v_i in 1, cmd_ready_and_o out 1: command handshake.
- cmd_addr_i  in  paddr_width_p  byte address, 8B aligned.
- cmd_wr_i  in  1  1=write, 0=read.
- cmd_len_i  in  2  beats minus one.
- cmd_data_i in 64, cmd_data_v_i in 1, cmd_data_ready_and_o out 1: write data.
- resp_v_o out 1, resp_ready_and_i in 1: response handshake.
- resp_data_o  out  64  read data.
- resp_wr_o  out  1  write acknowledge.
- resp_last_o  out  1  final response beat.
- resp_err_o  out  1  error.
- m_axi_araddr out axi_addr_width_p, m_axi_arlen out 8, m_axi_arvalid out 1, m_axi_arready in 1.
- m_axi_rdata in 64, m_axi_rresp in 2, m_axi_rlast in 1, m_axi_rvalid in 1, m_axi_rready out 1.
- m_axi_awaddr out axi_addr_width_p, m_axi_awlen out 8, m_axi_awvalid out 1, m_axi_awready in 1.
- m_axi_wdata out 64, m_axi_wstrb out 8, m_axi_wlast out 1, m_axi_wvalid out 1, m_axi_wready in 1.
- m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.

Function
REQ-007 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, ERR.
REQ-008 SHALL assert cmd_ready_and_o only in IDLE; one transaction outstanding at a time.
REQ-009 On cmd accept SHALL register addr/len/wr; next state RD_ADDR, WR_ADDR, or ERR if cmd_addr_i < dram_base_p.
REQ-010 SHALL drive axaddr = (cmd_addr - dram_base_p) truncated to axi_addr_width_p; axlen = zero-extended len; burst INCR, size 3 fixed.
REQ-011 ar/awvalid SHALL assert the cycle after command accept and hold, address stable, until ready.
REQ-012 RD_DATA: m_axi_rready = resp_ready_and_i; resp_v_o = m_axi_rvalid; resp_data_o = rdata; resp_last_o = rlast; resp_err_o = rresp[1]; zero added latency.
REQ-013 RD_DATA SHALL return to IDLE on handshake of the rlast beat.
REQ-014 WR_ADDR SHALL wait for awready, then enter WR_DATA; W data SHALL NOT precede AW accept.
REQ-015 WR_DATA: wvalid = cmd_data_v_i; cmd_data_ready_and_o = wready; wstrb = 8'hFF; 2-bit beat counter; wlast when counter == len.
REQ-016 After wlast handshake SHALL enter WR_RESP, bready = 1 until bvalid.
REQ-017 On B handshake SHALL capture bresp and present one response beat: resp_wr_o=1, resp_last_o=1, resp_err_o=bresp[1], resp_data_o=0; IDLE on resp handshake.
REQ-018 ERR SHALL issue no AXI traffic; present one response beat resp_err_o=1, resp_last_o=1, resp_wr_o=registered wr; write data beats SHALL be drained (accepted, discarded) before the response.
REQ-019 cmd_data_ready_and_o SHALL be 0 outside WR_DATA and ERR drain.
REQ-020 Address and len outputs SHALL be registered; no combinational path cmd_v_i to AXI valids.

Reset
REQ-021 aresetn low SHALL asynchronously force IDLE, beat counter 0, all valid/ready/last/err outputs 0, addresses/len 0.
REQ-022 Reset mid-transaction SHALL abandon it without response; first command after deassertion processed normally.

Verification
REQ-023 Read addr 34'h0_8000_1000 len 3, rready-held resp -> araddr 32'h0000_1000, arlen 3, 4 beats forwarded, resp_last on beat 4.
REQ-024 Write addr 34'h0_8000_0040 len 0, data 64'hDEAD_BEEF, bresp 0 -> awaddr 32'h40, one W beat wlast=1, resp_wr=1, err=0.
REQ-025 Write len 3 with wready toggling each cycle and awready delayed 5 cycles -> no W before AW, wlast only on beat 4, data order preserved.
REQ-026 Read addr 34'h0_0000_1000 -> no ar/awvalid, single resp err=1 last=1.
REQ-027 Read returning rresp=2'b10 on beat 2 with resp_ready_and_i low 3 cycles -> resp_err on beat 2 only, rready tracks resp_ready.
REQ-028 aresetn pulsed low during WR_DATA beat 2 -> all outputs 0 immediately; next read completes correctly.
